// File: rtl/spi_master_arbiter_if.sv
// Requester and spi_master signal bundle for spi_master_arbiter.
// The master modport is the arbiter's view; the slave modport is the environment's view.
interface spi_master_arbiter_if #(
  parameter int unsigned AW = 5,
  parameter int unsigned DW = 8
);
  logic [1:0]      req_valid;
  logic [1:0]      req_wr;
  logic [2*AW-1:0] req_addr;
  logic [2*DW-1:0] req_wdata;
  logic [1:0]      req_cs;
  logic [1:0]      req_ready;
  logic [1:0]      rsp_valid;
  logic [DW-1:0]   rsp_data;
  logic            rsp_err;
  logic [AW+DW:0]  m_data;
  logic            m_tx_valid;
  logic            m_cs_sel;
  logic            m_rx_ready;
  logic [DW-1:0]   m_data_out;

  modport master (
    input  req_valid, req_wr, req_addr, req_wdata, req_cs, m_rx_ready, m_data_out,
    output req_ready, rsp_valid, rsp_data, rsp_err, m_data, m_tx_valid, m_cs_sel
  );

  modport slave (
    output req_valid, req_wr, req_addr, req_wdata, req_cs, m_rx_ready, m_data_out,
    input  req_ready, rsp_valid, rsp_data, rsp_err, m_data, m_tx_valid, m_cs_sel
  );
endinterface

// File: rtl/spi_master_arbiter.sv
// Round-robin arbiter sharing one spi_master between two requesters.
// It runs one transaction at a time and aborts a transaction if the master does not answer within TIMEOUT cycles.
module spi_master_arbiter #(
  parameter int unsigned AW      = 5,
  parameter int unsigned DW      = 8,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  spi_master_arbiter_if.master bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [7:0] LP_LAST_CNT = 8'(TIMEOUT - 1);

  state_t         r_state;
  logic           r_last;
  logic           r_gnt;
  logic [7:0]     r_cnt;
  logic [1:0]     r_req_ready;
  logic [1:0]     r_rsp_valid;
  logic [DW-1:0]  r_rsp_data;
  logic           r_rsp_err;
  logic [AW+DW:0] r_m_data;
  logic           r_m_tx_valid;
  logic           r_m_cs_sel;

  logic           w_gnt;
  logic           w_cs;
  logic [AW+DW:0] w_frame;

  // With both requesters valid, grant the one that was not served last.
  assign w_gnt   = (bus.req_valid == 2'b11) ? ~r_last : bus.req_valid[1];
  assign w_cs    = w_gnt ? bus.req_cs[1] : bus.req_cs[0];
  assign w_frame = w_gnt ? {bus.req_wr[1], bus.req_addr[2*AW-1:AW], bus.req_wdata[2*DW-1:DW]}
                         : {bus.req_wr[0], bus.req_addr[AW-1:0],    bus.req_wdata[DW-1:0]};

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_last       <= 1'b1;
      r_gnt        <= 1'b0;
      r_cnt        <= '0;
      r_req_ready  <= '0;
      r_rsp_valid  <= '0;
      r_rsp_data   <= '0;
      r_rsp_err    <= 1'b0;
      r_m_data     <= '0;
      r_m_tx_valid <= 1'b0;
      r_m_cs_sel   <= 1'b1;
    end else begin
      r_req_ready  <= '0;
      r_rsp_valid  <= '0;
      r_m_tx_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.req_valid != 2'b00) begin
            r_gnt        <= w_gnt;
            r_m_data     <= w_frame;
            r_m_cs_sel   <= w_cs;
            r_req_ready  <= {w_gnt, ~w_gnt};
            r_m_tx_valid <= 1'b1;
            r_state      <= ISSUE;
          end
        end
        ISSUE: begin
          r_cnt   <= '0;
          r_state <= WAIT;
        end
        WAIT: begin
          r_cnt <= r_cnt + 8'd1;
          // A completion arriving on the final count still counts as success.
          if (bus.m_rx_ready) begin
            r_rsp_data  <= bus.m_data_out;
            r_rsp_err   <= 1'b0;
            r_rsp_valid <= {r_gnt, ~r_gnt};
            r_state     <= RESP;
          end else if (r_cnt == LP_LAST_CNT) begin
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b1;
            r_rsp_valid <= {r_gnt, ~r_gnt};
            r_state     <= RESP;
          end
        end
        RESP: begin
          r_last  <= r_gnt;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready  = r_req_ready;
  assign bus.rsp_valid  = r_rsp_valid;
  assign bus.rsp_data   = r_rsp_data;
  assign bus.rsp_err    = r_rsp_err;
  assign bus.m_data     = r_m_data;
  assign bus.m_tx_valid = r_m_tx_valid;
  assign bus.m_cs_sel   = r_m_cs_sel;
endmodule

// File: tb/tb_spi_master_arbiter.sv
// Scoreboard bench for spi_master_arbiter: the bench models two requesters and a scripted spi_master.
// Expected issues and responses are queued in predicted grant order.
module tb_spi_master_arbiter;
  localparam int unsigned AW = 5;
  localparam int unsigned DW = 8;
  localparam int unsigned TO = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spi_master_arbiter_if #(.AW(AW), .DW(DW)) bus ();
  spi_master_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct { logic wr; logic [AW-1:0] addr; logic [DW-1:0] wdata; logic cs; } req_t;
  typedef struct { logic [1:0] ready; logic [AW+DW:0] frame; logic cs; int delay; logic [DW-1:0] rdata; } iss_t;
  typedef struct { logic [1:0] valid; logic [DW-1:0] data; logic err; int lat; } rsp_t;

  req_t rq0[$];
  req_t rq1[$];
  iss_t iss_q[$];
  rsp_t rsp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int tx_cyc = 0;
  int cd = -1;
  logic [DW-1:0] rx_data = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic load(input int i);
    req_t r;
    if (i == 0) begin
      if (rq0.size() == 0) begin bus.req_valid[0] = 1'b0; return; end
      r = rq0.pop_front();
    end else begin
      if (rq1.size() == 0) begin bus.req_valid[1] = 1'b0; return; end
      r = rq1.pop_front();
    end
    bus.req_wr[i]              = r.wr;
    bus.req_addr[AW*i +: AW]   = r.addr;
    bus.req_wdata[DW*i +: DW]  = r.wdata;
    bus.req_cs[i]              = r.cs;
    bus.req_valid[i]           = 1'b1;
  endtask

  // delay: cycles from m_tx_valid to m_rx_ready; negative means the master never answers.
  task automatic txn(input int i, input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                     input logic cs, input int delay, input logic [DW-1:0] rdata, input bit with_rsp);
    req_t q;
    iss_t e;
    rsp_t r;
    q.wr = wr; q.addr = addr; q.wdata = wdata; q.cs = cs;
    if (i == 0) rq0.push_back(q); else rq1.push_back(q);
    if (bus.req_valid[i] == 1'b0) load(i);
    e.ready = (i == 0) ? 2'b01 : 2'b10;
    e.frame = {wr, addr, wdata};
    e.cs    = cs;
    e.delay = delay;
    e.rdata = rdata;
    iss_q.push_back(e);
    if (with_rsp) begin
      r.valid = e.ready;
      if (delay >= 1 && delay <= int'(TO)) begin
        r.data = rdata; r.err = 1'b0; r.lat = delay + 1;
      end else begin
        r.data = '0; r.err = 1'b1; r.lat = int'(TO) + 1;
      end
      rsp_q.push_back(r);
    end
  endtask

  task automatic tick();
    iss_t e;
    rsp_t r;
    @(posedge clk);
    #1;
    cyc++;
    bus.m_rx_ready = 1'b0;
    if (cd > 0) begin
      cd--;
      if (cd == 0) begin
        bus.m_rx_ready = 1'b1;
        bus.m_data_out = rx_data;
      end
    end
    if (bus.req_ready != 2'b00 || bus.m_tx_valid) begin
      if (iss_q.size() == 0) begin
        chk("iss_unexpected", 32'({bus.req_ready, bus.m_tx_valid}), 32'd0);
      end else begin
        e = iss_q.pop_front();
        chk("req_ready", 32'(bus.req_ready), 32'(e.ready));
        chk("m_tx_valid", 32'(bus.m_tx_valid), 32'd1);
        chk("m_data", 32'(bus.m_data), 32'(e.frame));
        chk("m_cs_sel", 32'(bus.m_cs_sel), 32'(e.cs));
        tx_cyc  = cyc;
        cd      = (e.delay > 0) ? e.delay : -1;
        rx_data = e.rdata;
      end
      for (int i = 0; i < 2; i++) if (bus.req_ready[i]) load(i);
    end
    if (bus.rsp_valid != 2'b00) begin
      if (rsp_q.size() == 0) begin
        chk("rsp_unexpected", 32'(bus.rsp_valid), 32'd0);
      end else begin
        r = rsp_q.pop_front();
        chk("rsp_valid", 32'(bus.rsp_valid), 32'(r.valid));
        chk("rsp_data", 32'(bus.rsp_data), 32'(r.data));
        chk("rsp_err", 32'(bus.rsp_err), 32'(r.err));
        chk("rsp_latency", 32'(cyc - tx_cyc), 32'(r.lat));
      end
    end
  endtask

  task automatic wait_done(input int maxc);
    int n;
    n = 0;
    while ((iss_q.size() != 0 || rsp_q.size() != 0) && n < maxc) begin
      tick();
      n++;
    end
    chk("drain", 32'(iss_q.size() + rsp_q.size()), 32'd0);
    repeat (2) tick();
  endtask

  task automatic check_reset();
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
    chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
    chk("rst_m_tx_valid", 32'(bus.m_tx_valid), 32'd0);
    chk("rst_m_data", 32'(bus.m_data), 32'd0);
    chk("rst_m_cs_sel", 32'(bus.m_cs_sel), 32'd1);
  endtask

  initial begin
    int n;
    rst            = 1'b0;
    bus.req_valid  = '0;
    bus.req_wr     = '0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.req_cs     = '1;
    bus.m_rx_ready = 1'b0;
    bus.m_data_out = '0;

    // Reset held with both requesters waiting; requester 0 must win first.
    txn(0, 1'b0, 5'h04, 8'h00, 1'b1, 6, 8'hA5, 1'b1);
    txn(1, 1'b1, 5'h0E, 8'h89, 1'b0, 4, 8'h3C, 1'b1);
    tick();
    tick();
    check_reset();
    rst = 1'b1;
    wait_done(100);

    // Round-robin with both requesters continuously valid.
    txn(0, 1'b0, 5'h01, 8'h11, 1'b1, 3, 8'h51, 1'b1);
    txn(1, 1'b1, 5'h02, 8'h22, 1'b1, 2, 8'h52, 1'b1);
    txn(0, 1'b1, 5'h03, 8'h33, 1'b0, 5, 8'h53, 1'b1);
    txn(1, 1'b0, 5'h04, 8'h44, 1'b1, 1, 8'h54, 1'b1);
    wait_done(200);

    // Master silent: timeout, then a normal request.
    txn(0, 1'b0, 5'h1F, 8'h00, 1'b1, -1, 8'h00, 1'b1);
    txn(1, 1'b0, 5'h10, 8'h00, 1'b1, 3, 8'hC3, 1'b1);
    wait_done(100);

    // Completion on the final WAIT cycle, then one landing a cycle too late.
    txn(0, 1'b0, 5'h07, 8'h00, 1'b1, int'(TO), 8'h7E, 1'b1);
    txn(1, 1'b1, 5'h15, 8'hAA, 1'b0, int'(TO) + 1, 8'hE7, 1'b1);
    wait_done(100);

    // Reset in the middle of WAIT abandons the transaction.
    txn(1, 1'b0, 5'h0A, 8'h00, 1'b0, -1, 8'h00, 1'b0);
    n = 0;
    while (iss_q.size() != 0 && n < 20) begin
      tick();
      n++;
    end
    chk("midwait_issue", 32'(iss_q.size()), 32'd0);
    repeat (3) tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    cd  = -1;
    check_reset();
    txn(0, 1'b0, 5'h0B, 8'h00, 1'b1, 2, 8'h42, 1'b1);
    tick();
    chk("post_rst_grant", 32'(bus.req_ready), 32'd1);
    wait_done(50);
    repeat (10) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
